// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory-controller port between the fetch unit
// (IF) and the execute unit (EX). Each access walks IDLE -> ACCESS -> CAPTURE
// -> IDLE, so a request sampled in IDLE completes two cycles later and the
// next grant can happen one cycle after that.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN undefined : fixed priority, EX wins every tie.
//   MEM_ARB_ROUND_ROBIN_EN defined   : ties go to the requester that was not
//                                      granted last (EX first after reset).
//
// Handshake: a requester raises req with stable operands and holds it until
// its done pulse. It drops req in the cycle after done. Operands are latched
// at the grant edge, so later changes to req/addr/data are ignored until IDLE.
// A req still high when IDLE is re-entered is treated as a new request.

package memory_utils;
  // 12-bit machine word used for every address and data path.
  typedef logic [11:0] word_t;

  // Encoding of mem_read_type toward the memory controller.
  localparam logic INSTRUCTION_FETCH = 1'b0;
  localparam logic DATA_READ         = 1'b1;
endpackage

module memory_arbiter
  import memory_utils::*;
(
  input  logic        clk,
  input  logic        rst_n,
  // fetch unit
  input  logic        if_req,
  input  logic [11:0] if_addr,
  output logic        if_done,
  // execute unit
  input  logic        ex_req,
  input  logic        ex_we,
  input  logic [11:0] ex_addr,
  input  logic [11:0] ex_wdata,
  output logic        ex_done,
  // shared read data
  output logic [11:0] rdata,
  // memory controller
  output logic [11:0] mem_address,
  output logic [11:0] mem_write_data,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic        mem_read_type,
  input  logic [11:0] mem_read_data,
  // status
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t r_state;
  logic   r_owner_ex;   // 1: current access belongs to EX, 0: to IF
  logic   r_we;         // latched operation of the current access
  word_t  r_rdata;
  word_t  r_addr;
  word_t  r_wdata;
  logic   r_rd_en;
  logic   r_wr_en;
  logic   r_rd_type;
  logic   r_if_done;
  logic   r_ex_done;

  logic   w_any_req;
  logic   w_grant_ex;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1: EX was granted last, 0: IF was granted last (reset prefers EX).
  logic   r_last_ex;

  // Round-robin tie break: EX wins unless IF is also asking and EX went last.
  always_comb begin
    w_grant_ex = ex_req & (~if_req | ~r_last_ex);
  end

  // Remember which requester received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ex <= 1'b0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_last_ex <= w_grant_ex;
    end
  end
`else
  // Fixed priority: EX takes every cycle in which it is requesting.
  always_comb begin
    w_grant_ex = ex_req;
  end
`endif

  assign w_any_req = if_req | ex_req;

  // Arbitration FSM; every controller-facing output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner_ex <= 1'b0;
      r_we       <= 1'b0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_type  <= 1'b0;
      r_if_done  <= 1'b0;
      r_ex_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_if_done <= 1'b0;
          r_ex_done <= 1'b0;
          if (w_any_req) begin
            r_state    <= S_ACCESS;
            r_owner_ex <= w_grant_ex;
            if (w_grant_ex) begin
              r_addr    <= ex_addr;
              r_wdata   <= ex_wdata;
              r_we      <= ex_we;
              r_wr_en   <= ex_we;
              r_rd_en   <= ~ex_we;
              r_rd_type <= DATA_READ;
            end else begin
              // Fetches are always reads; write data keeps its last value.
              r_addr    <= if_addr;
              r_we      <= 1'b0;
              r_wr_en   <= 1'b0;
              r_rd_en   <= 1'b1;
              r_rd_type <= INSTRUCTION_FETCH;
            end
          end
        end

        S_ACCESS: begin
          // Enables last exactly one cycle; read data is sampled on this edge.
          r_state <= S_CAPTURE;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          if (!r_we) begin
            r_rdata <= mem_read_data;
          end
          r_ex_done <= r_owner_ex;
          r_if_done <= ~r_owner_ex;
        end

        S_CAPTURE: begin
          // Done was visible for this one cycle; address/data stay put.
          r_state   <= S_IDLE;
          r_if_done <= 1'b0;
          r_ex_done <= 1'b0;
        end

        default: begin
          r_state   <= S_IDLE;
          r_rd_en   <= 1'b0;
          r_wr_en   <= 1'b0;
          r_if_done <= 1'b0;
          r_ex_done <= 1'b0;
        end
      endcase
    end
  end

  assign if_done          = r_if_done;
  assign ex_done          = r_ex_done;
  assign rdata            = r_rdata;
  assign mem_address      = r_addr;
  assign mem_write_data   = r_wdata;
  assign mem_read_enable  = r_rd_en;
  assign mem_write_enable = r_wr_en;
  assign mem_read_type    = r_rd_type;
  assign busy             = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed transactions against a small memory
// model, with expected completions and expected controller accesses queued
// by the driver and checked by an independent monitor.
module tb_memory_arbiter;
  import memory_utils::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_done;
  logic        ex_req;
  logic        ex_we;
  logic [11:0] ex_addr;
  logic [11:0] ex_wdata;
  logic        ex_done;
  logic [11:0] rdata;
  logic [11:0] mem_address;
  logic [11:0] mem_write_data;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        mem_read_type;
  logic [11:0] mem_read_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // completion entry: [57] is_ex, [56] check rdata, [55:44] rdata,
  //                   [43:32] address held, [31:0] cycle of done
  logic [57:0] exp_q[$];
  // access entry: [25] we, [24] read type, [23:12] address, [11:0] wdata
  logic [25:0] acc_q[$];
  logic [57:0] e;
  logic [25:0] a;

  logic [11:0] mem [0:4095];

  memory_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_done          (if_done),
    .ex_req           (ex_req),
    .ex_we            (ex_we),
    .ex_addr          (ex_addr),
    .ex_wdata         (ex_wdata),
    .ex_done          (ex_done),
    .rdata            (rdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_read_type    (mem_read_type),
    .mem_read_data    (mem_read_data),
    .busy             (busy),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_read_data = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic wait_done(input bit want_ex);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (want_ex ? ex_done : if_done) seen = 1'b1;
    end
    n_total++;
    if (!seen) begin
      n_bad++;
      $display("FAIL wait_done(%0d): no done within 20 cycles", want_ex);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(mem_read_enable), 32'd0);
    check({tag, "_wr_en"}, 32'(mem_write_enable), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
  endtask

  // One complete single-requester transaction.
  task automatic single(input bit is_ex, input bit we, input logic [11:0] addr,
                        input logic [11:0] wdata, input logic [11:0] exp_rd);
    @(posedge clk); #1;
    acc_q.push_back({we, (is_ex ? DATA_READ : INSTRUCTION_FETCH), addr, wdata});
    exp_q.push_back({is_ex, 1'b1, exp_rd, addr, 32'(cyc + 2)});
    if (is_ex) begin
      ex_req = 1'b1; ex_we = we; ex_addr = addr; ex_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    wait_done(is_ex);
    @(posedge clk); #1;
    if_req = 1'b0; ex_req = 1'b0; ex_we = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    #1 check_reset_outputs("pulse_rst");
    @(negedge clk); rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    n_total++;
    if (mem_read_enable && mem_write_enable) begin
      n_bad++;
      $display("FAIL enables_exclusive: rd=%0b wr=%0b", mem_read_enable, mem_write_enable);
    end
    n_total++;
    if (if_done && ex_done) begin
      n_bad++;
      $display("FAIL done_exclusive: if_done=%0b ex_done=%0b", if_done, ex_done);
    end
    if (mem_read_enable || mem_write_enable) begin
      n_total++;
      if (acc_q.size() == 0) begin
        n_bad++;
        $display("FAIL access_unexpected: addr=%0o rd=%0b wr=%0b", mem_address, mem_read_enable, mem_write_enable);
      end else begin
        n_total--;
        a = acc_q.pop_front();
        check("acc_we", 32'(mem_write_enable), 32'(a[25]));
        check("acc_addr", 32'(mem_address), 32'(a[23:12]));
        check("acc_busy", 32'(busy), 32'd1);
        if (a[25]) check("acc_wdata", 32'(mem_write_data), 32'(a[11:0]));
        else       check("acc_rtype", 32'(mem_read_type), 32'(a[24]));
      end
    end
    if (if_done || ex_done) begin
      n_total++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: if_done=%0b ex_done=%0b cyc=%0d", if_done, ex_done, cyc);
      end else begin
        n_total--;
        e = exp_q.pop_front();
        check("done_owner", 32'(ex_done), 32'(e[57]));
        check("done_cycle", 32'(cyc), e[31:0]);
        check("done_addr_held", 32'(mem_address), 32'(e[43:32]));
        check("done_busy", 32'(busy), 32'd1);
        if (e[56]) check("done_rdata", 32'(rdata), 32'(e[55:44]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 12'o0000;
    mem[12'o0200] = 12'o7402;
    mem[12'o0051] = 12'o4321;
    mem[12'o0300] = 12'o0011;
    mem[12'o0100] = 12'o0777;
    mem[12'o7777] = 12'o0001;
    mem[12'o0000] = 12'o2525;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    ex_req = 1'b0; ex_we = 1'b0; ex_addr = '0; ex_wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_if_done", 32'(if_done), 32'd0);
    check("reset_ex_done", 32'(ex_done), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // fetch 0200 -> 7402
    single(1'b0, 1'b0, 12'o0200, 12'o0000, 12'o7402);
    // execute write 0050 <- 1234, rdata unchanged
    single(1'b1, 1'b1, 12'o0050, 12'o1234, 12'o7402);
    // execute read back
    single(1'b1, 1'b0, 12'o0050, 12'o0000, 12'o1234);
    single(1'b1, 1'b0, 12'o0051, 12'o0000, 12'o4321);
    // address extremes
    single(1'b0, 1'b0, 12'o7777, 12'o0000, 12'o0001);
    single(1'b1, 1'b0, 12'o0000, 12'o0000, 12'o2525);

    // operands changed during ACCESS are ignored
    @(posedge clk); #1;
    acc_q.push_back({1'b0, DATA_READ, 12'o0100, 12'o0000});
    exp_q.push_back({1'b1, 1'b1, 12'o0777, 12'o0100, 32'(cyc + 2)});
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 12'o0100;
    @(posedge clk); #1;
    ex_we = 1'b1; ex_addr = 12'o0200; ex_wdata = 12'o5555;
    wait_done(1'b1);
    @(posedge clk); #1;
    ex_req = 1'b0; ex_we = 1'b0;
    // the ignored write must not have reached 0200
    single(1'b0, 1'b0, 12'o0200, 12'o0000, 12'o7402);

    // tie handling from a fresh reset
    pulse_reset();
    @(posedge clk); #1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    acc_q.push_back({1'b0, DATA_READ, 12'o0051, 12'o0000});
    exp_q.push_back({1'b1, 1'b1, 12'o4321, 12'o0051, 32'(cyc + 2)});
    acc_q.push_back({1'b0, INSTRUCTION_FETCH, 12'o0300, 12'o0000});
    exp_q.push_back({1'b0, 1'b1, 12'o0011, 12'o0300, 32'(cyc + 5)});
    acc_q.push_back({1'b0, DATA_READ, 12'o0051, 12'o0000});
    exp_q.push_back({1'b1, 1'b1, 12'o4321, 12'o0051, 32'(cyc + 8)});
    acc_q.push_back({1'b0, INSTRUCTION_FETCH, 12'o0300, 12'o0000});
    exp_q.push_back({1'b0, 1'b1, 12'o0011, 12'o0300, 32'(cyc + 11)});
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 12'o0051;
    if_req = 1'b1; if_addr = 12'o0300;
    wait_done(1'b1);
    wait_done(1'b0);
    wait_done(1'b1);
    wait_done(1'b0);
    @(posedge clk); #1;
    ex_req = 1'b0; if_req = 1'b0;
`else
    acc_q.push_back({1'b0, DATA_READ, 12'o0051, 12'o0000});
    exp_q.push_back({1'b1, 1'b1, 12'o4321, 12'o0051, 32'(cyc + 2)});
    acc_q.push_back({1'b0, INSTRUCTION_FETCH, 12'o0300, 12'o0000});
    exp_q.push_back({1'b0, 1'b1, 12'o0011, 12'o0300, 32'(cyc + 5)});
    ex_req = 1'b1; ex_we = 1'b0; ex_addr = 12'o0051;
    if_req = 1'b1; if_addr = 12'o0300;
    wait_done(1'b1);
    @(posedge clk); #1;
    ex_req = 1'b0;
    wait_done(1'b0);
    @(posedge clk); #1;
    if_req = 1'b0;
`endif

    // reset during ACCESS aborts with no done, reissue completes
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 12'o0200;
    @(posedge clk); #1;
    check("abort_in_access", 32'(mem_read_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rd_en", 32'(mem_read_enable), 32'd0);
    check("abort_wr_en", 32'(mem_write_enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_no_if_done", 32'(if_done), 32'd0);
    acc_q.push_back({1'b0, INSTRUCTION_FETCH, 12'o0200, 12'o0000});
    exp_q.push_back({1'b0, 1'b1, 12'o7402, 12'o0200, 32'(cyc + 2)});
    rst_n = 1'b1;
    wait_done(1'b0);
    @(posedge clk); #1;
    if_req = 1'b0;

    repeat (4) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("acc_q_empty", 32'(acc_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
